// File: rtl/bpsk_pkg.sv
// Shared BPSK definitions: symbol geometry, datapath widths and the 52-entry sine table.
// Used by both the modulator and the demodulator.
package bpsk_pkg;

    localparam int SYMBOL_LEN = 52;
    localparam int SAMPLE_W   = 8;
    localparam int CORR_W     = 20;
    localparam int IDX_W      = 6;
    localparam int PROD_W     = 2 * SAMPLE_W;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic signed [CORR_W-1:0]   corr_t;
    typedef logic        [IDX_W-1:0]    idx_t;

    // First half-period holds the positive lobe; the second half is its negation.
    function automatic sample_t sine_at(input idx_t i);
        idx_t    h;
        logic    neg;
        sample_t mag;
        neg = (i >= idx_t'(SYMBOL_LEN / 2));
        h   = neg ? i - idx_t'(SYMBOL_LEN / 2) : i;
        case (h)
            6'd0:    mag = 8'sd0;
            6'd1:    mag = 8'sd9;
            6'd2:    mag = 8'sd18;
            6'd3:    mag = 8'sd27;
            6'd4:    mag = 8'sd36;
            6'd5:    mag = 8'sd44;
            6'd6:    mag = 8'sd51;
            6'd7:    mag = 8'sd58;
            6'd8:    mag = 8'sd64;
            6'd9:    mag = 8'sd69;
            6'd10:   mag = 8'sd73;
            6'd11:   mag = 8'sd75;
            6'd12:   mag = 8'sd77;
            6'd13:   mag = 8'sd78;
            6'd14:   mag = 8'sd77;
            6'd15:   mag = 8'sd75;
            6'd16:   mag = 8'sd73;
            6'd17:   mag = 8'sd69;
            6'd18:   mag = 8'sd64;
            6'd19:   mag = 8'sd58;
            6'd20:   mag = 8'sd51;
            6'd21:   mag = 8'sd44;
            6'd22:   mag = 8'sd36;
            6'd23:   mag = 8'sd27;
            6'd24:   mag = 8'sd18;
            6'd25:   mag = 8'sd9;
            default: mag = 8'sd0;
        endcase
        if (i >= idx_t'(SYMBOL_LEN))
            return '0;
        return neg ? -mag : mag;
    endfunction

endpackage

// File: rtl/sine_lut.sv
// Combinational sine table lookup, 6-bit phase index to signed 8-bit sample.
import bpsk_pkg::*;

module sine_lut (
    input  logic [IDX_W-1:0]           idx,
    output logic signed [SAMPLE_W-1:0] value
);

    assign value = sine_at(idx);

endmodule

// File: rtl/bpsk_demod.sv
// BPSK demodulator: correlates each 52-sample symbol against the sine table
// and emits one recovered bit per symbol with its correlation and a confidence flag.
module bpsk_demod
    import bpsk_pkg::*;
#(
    parameter int unsigned THRESH = 39113
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic signed [SAMPLE_W-1:0] sample_in,
    input  logic                       sample_valid,
    input  logic                       resync,
    output logic                       data_out,
    output logic                       data_valid,
    output logic signed [CORR_W-1:0]   corr_out,
    output logic                       low_conf
);

    logic [IDX_W-1:0]           idx;
    logic signed [CORR_W-1:0]   acc;
    logic signed [SAMPLE_W-1:0] lut_val;
    logic signed [PROD_W-1:0]   prod;
    logic signed [CORR_W-1:0]   prod_ext;
    logic signed [CORR_W-1:0]   final_sum;
    logic [CORR_W:0]            mag;
    logic                       is_last;

    sine_lut u_lut (
        .idx   (idx),
        .value (lut_val)
    );

    assign prod      = sample_in * lut_val;
    assign prod_ext  = {{(CORR_W - PROD_W){prod[PROD_W-1]}}, prod};
    assign final_sum = acc + prod_ext;
    assign is_last   = (idx == IDX_W'(SYMBOL_LEN - 1));

    // One extra bit so negating the most negative sum cannot wrap.
    always_comb begin
        mag = {final_sum[CORR_W-1], final_sum};
        if (final_sum[CORR_W-1])
            mag = '0 - {1'b1, final_sum};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx        <= '0;
            acc        <= '0;
            data_out   <= 1'b0;
            data_valid <= 1'b0;
            corr_out   <= '0;
            low_conf   <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (resync) begin
                if (sample_valid) begin
                    acc <= prod_ext;
                    idx <= IDX_W'(1);
                end else begin
                    acc <= '0;
                    idx <= '0;
                end
            end else if (sample_valid) begin
                if (is_last) begin
                    corr_out   <= final_sum;
                    data_out   <= ~final_sum[CORR_W-1];
                    low_conf   <= (mag < (CORR_W + 1)'(THRESH));
                    data_valid <= 1'b1;
                    acc        <= '0;
                    idx        <= '0;
                end else begin
                    acc <= final_sum;
                    idx <= idx + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_bpsk_demod.sv
// Directed self-checking bench for bpsk_demod using hand-derived correlation values.
`timescale 1ns/1ps
module tb_bpsk_demod;

    localparam int IDEAL = 156452;

    logic              clk;
    logic              reset;
    logic signed [7:0] sample_in;
    logic              sample_valid;
    logic              resync;
    logic              data_out;
    logic              data_valid;
    logic signed [19:0] corr_out;
    logic              low_conf;

    int checks;
    int passed;

    int half_tbl [26] = '{0, 9, 18, 27, 36, 44, 51, 58, 64, 69, 73, 75, 77,
                          78, 77, 75, 73, 69, 64, 58, 51, 44, 36, 27, 18, 9};

    bpsk_demod #(.THRESH(39113)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .resync       (resync),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .corr_out     (corr_out),
        .low_conf     (low_conf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lutv(input int i);
        return (i < 26) ? half_tbl[i] : -half_tbl[i - 26];
    endfunction

    // Drive one cycle of inputs on the falling edge, return just after the rising edge.
    task automatic send(input logic v, input int s, input logic rs);
        @(negedge clk);
        sample_valid = v;
        sample_in    = 8'(s);
        resync       = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        send(1'b0, 0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b0; sample_valid = 1'b0; sample_in = '0; resync = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (data_valid !== 1'b0) $display("FAIL reset_dv got=%b exp=0", data_valid); else passed++;
        checks++; if (data_out !== 1'b0) $display("FAIL reset_do got=%b exp=0", data_out); else passed++;
        checks++; if (corr_out !== 20'sd0) $display("FAIL reset_corr got=%0d exp=0", corr_out); else passed++;
        checks++; if (low_conf !== 1'b0) $display("FAIL reset_lc got=%b exp=0", low_conf); else passed++;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Sends 52 samples LUT[(i+off)%52]*scale; checks no early pulse and the final decision.
    task automatic run_symbol(input string name, input int off, input int scale,
                              input int exp_corr, input logic exp_do, input logic exp_lc);
        int early;
        early = 0;
        for (int i = 0; i < 52; i++) begin
            send(1'b1, scale * lutv((i + off) % 52), 1'b0);
            if (i < 51 && data_valid) early++;
        end
        checks++; if (early !== 0) $display("FAIL %s_early got=%0d exp=0", name, early); else passed++;
        checks++; if (data_valid !== 1'b1) $display("FAIL %s_dv got=%b exp=1", name, data_valid); else passed++;
        checks++; if (corr_out !== 20'(exp_corr)) $display("FAIL %s_corr got=%0d exp=%0d", name, corr_out, exp_corr); else passed++;
        checks++; if (data_out !== exp_do) $display("FAIL %s_do got=%b exp=%b", name, data_out, exp_do); else passed++;
        checks++; if (low_conf !== exp_lc) $display("FAIL %s_lc got=%b exp=%b", name, low_conf, exp_lc); else passed++;
        idle();
        checks++; if (data_valid !== 1'b0) $display("FAIL %s_pulse_width got=%b exp=0", name, data_valid); else passed++;
        checks++; if (data_out !== exp_do) $display("FAIL %s_hold got=%b exp=%b", name, data_out, exp_do); else passed++;
    endtask

    task automatic test_ideal_one();
        run_symbol("bit1", 0, 1, IDEAL, 1'b1, 1'b0);
    endtask

    task automatic test_ideal_zero();
        run_symbol("bit0", 26, 1, -IDEAL, 1'b0, 1'b0);
    endtask

    task automatic test_zero_input();
        run_symbol("zero", 0, 0, 0, 1'b1, 1'b1);
    endtask

    task automatic test_resync_mid();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            send(1'b1, lutv(i), 1'b0);
            if (data_valid) pulses++;
        end
        send(1'b1, lutv(0), 1'b1);
        if (data_valid) pulses++;
        checks++; if (corr_out !== 20'(-IDEAL)) $display("FAIL resync_keep_corr got=%0d exp=%0d", corr_out, -IDEAL); else passed++;
        checks++; if (data_out !== 1'b0) $display("FAIL resync_keep_do got=%b exp=0", data_out); else passed++;
        for (int i = 1; i < 51; i++) begin
            send(1'b1, lutv(i), 1'b0);
            if (data_valid) pulses++;
        end
        checks++; if (pulses !== 0) $display("FAIL resync_spurious got=%0d exp=0", pulses); else passed++;
        send(1'b1, lutv(51), 1'b0);
        checks++; if (data_valid !== 1'b1) $display("FAIL resync_dv got=%b exp=1", data_valid); else passed++;
        checks++; if (corr_out !== 20'(IDEAL)) $display("FAIL resync_corr got=%0d exp=%0d", corr_out, IDEAL); else passed++;
    endtask

    // Resync arriving with what would be the idx-51 sample must suppress the decision.
    task automatic test_resync_at_decision();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 51; i++) begin
            send(1'b1, lutv((i + 26) % 52), 1'b0);
            if (data_valid) pulses++;
        end
        send(1'b1, lutv(0), 1'b1);
        if (data_valid) pulses++;
        for (int i = 1; i < 51; i++) begin
            send(1'b1, lutv(i), 1'b0);
            if (data_valid) pulses++;
        end
        checks++; if (pulses !== 0) $display("FAIL resync51_spurious got=%0d exp=0", pulses); else passed++;
        send(1'b1, lutv(51), 1'b0);
        checks++; if (data_valid !== 1'b1) $display("FAIL resync51_dv got=%b exp=1", data_valid); else passed++;
        checks++; if (corr_out !== 20'(IDEAL)) $display("FAIL resync51_corr got=%0d exp=%0d", corr_out, IDEAL); else passed++;
    endtask

    task automatic test_gaps();
        int accepted, cyc, pulses, misplaced, bad_corr, sym;
        logic [2:0] bits;
        logic [2:0] pattern;
        pattern = 3'b101;
        accepted = 0; cyc = 0; pulses = 0; misplaced = 0; bad_corr = 0; bits = '0; sym = 0;
        while (accepted < 156 && cyc < 400) begin
            if (cyc % 3 == 2) begin
                send(1'b0, 99, 1'b0);
                if (data_valid) misplaced++;
            end else begin
                sym = accepted / 52;
                send(1'b1, lutv((accepted % 52 + (pattern[2 - sym] ? 0 : 26)) % 52), 1'b0);
                accepted++;
                if ((accepted % 52 == 0) != (data_valid == 1'b1)) misplaced++;
                if (data_valid) begin
                    if (pulses < 3) bits[2 - pulses] = data_out;
                    if (corr_out !== 20'(pattern[2 - sym] ? IDEAL : -IDEAL)) bad_corr++;
                    pulses++;
                end
            end
            cyc++;
        end
        idle();
        if (data_valid) misplaced++;
        checks++; if (pulses !== 3) $display("FAIL gaps_pulses got=%0d exp=3", pulses); else passed++;
        checks++; if (bits !== 3'b101) $display("FAIL gaps_bits got=%b exp=101", bits); else passed++;
        checks++; if (misplaced !== 0) $display("FAIL gaps_timing got=%0d exp=0", misplaced); else passed++;
        checks++; if (bad_corr !== 0) $display("FAIL gaps_corr got=%0d exp=0", bad_corr); else passed++;
    endtask

    task automatic test_async_reset();
        int early;
        for (int i = 0; i < 30; i++) send(1'b1, lutv(i), 1'b0);
        @(negedge clk);
        sample_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        checks++; if (data_out !== 1'b0) $display("FAIL areset_do got=%b exp=0", data_out); else passed++;
        checks++; if (corr_out !== 20'sd0) $display("FAIL areset_corr got=%0d exp=0", corr_out); else passed++;
        checks++; if (low_conf !== 1'b0) $display("FAIL areset_lc got=%b exp=0", low_conf); else passed++;
        checks++; if (data_valid !== 1'b0) $display("FAIL areset_dv got=%b exp=0", data_valid); else passed++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        early = 0;
        for (int i = 0; i < 52; i++) begin
            send(1'b1, lutv(i), 1'b0);
            if (i < 51 && data_valid) early++;
        end
        checks++; if (early !== 0) $display("FAIL areset_early got=%0d exp=0", early); else passed++;
        checks++; if (data_valid !== 1'b1) $display("FAIL areset_post_dv got=%b exp=1", data_valid); else passed++;
        checks++; if (corr_out !== 20'(IDEAL)) $display("FAIL areset_post_corr got=%0d exp=%0d", corr_out, IDEAL); else passed++;
        idle();
    endtask

    initial begin
        checks = 0;
        passed = 0;
        test_reset();
        test_ideal_one();
        test_ideal_zero();
        test_resync_mid();
        test_resync_at_decision();
        test_zero_input();
        test_gaps();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bpsk_demod.md
# bpsk_demod

Receive-side counterpart of the BPSK sine modulator. It consumes the modulator's 8-bit signed sample stream and correlates each 52-sample symbol against the shared sine table. At each symbol boundary it emits one recovered data bit: bit 1 for a 0° carrier, bit 0 for a 180° carrier. It sits downstream of the modulator, or of any channel model feeding it, in the loopback and test path.

## Interface
Parameters:
- `THRESH`, default 39113: low-confidence threshold on |correlation|. The default is about 1/4 of an ideal symbol.

Ports:
- `clk`, input, 1: single clock; all logic is on its rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `sample_in`, input, 8: signed two's-complement carrier sample.
- `sample_valid`, input, 1: `sample_in` is accepted on every cycle this is high. Gaps are allowed.
- `resync`, input, 1: synchronous symbol realignment.
- `data_out`, output, 1: recovered bit. Held until the next decision.
- `data_valid`, output, 1: one-cycle pulse per decision.
- `corr_out`, output, 20: signed final correlation of the last symbol.
- `low_conf`, output, 1: set when |`corr_out`| < `THRESH`. Held with `data_out`.

## Operation
- **State**
  - Phase counter `idx`: 0..51.
  - Signed accumulator `acc`: 20 bits.
- **Reset.** While `reset` is 0, all of the following are held at 0: `idx`, `acc`, `data_out`, `data_valid`, `corr_out`, `low_conf`.
- **Accepted sample** (`sample_valid` = 1):
  - prod = `sample_in` × `LUT[idx]`, a signed 8×8 → 16-bit product, sign-extended to 20 bits.
  - If `idx` < 51: `acc` ← `acc` + prod, then `idx` ← `idx` + 1.
  - If `idx` = 51 (decision):
    - final = `acc` + prod
    - `corr_out` ← final
    - `data_out` ← (final ≥ 0)
    - `low_conf` ← (|final| < `THRESH`)
    - `data_valid` ← 1
    - `acc` ← 0, `idx` ← 0 (wrap)
- **No sample** (`sample_valid` = 0): `idx` and `acc` hold.
- **`data_valid`** is 0 on every cycle other than the one following a decision.
- **Width rule.** Worst case |final| is 128 × Σ|LUT| = 128 × 2560 = 327680 < 2^19, so 20 bits never overflows. No saturation logic is needed.
- **Tie.** final = 0 gives `data_out` = 1 and `low_conf` = 1.
- **`resync` = 1:**
  - The partial symbol is discarded.
  - If `sample_valid` = 1 in the same cycle, that sample is treated as `idx` 0 of a new symbol: `acc` ← prod, `idx` ← 1.
  - Otherwise `acc` ← 0 and `idx` ← 0.
  - `resync` takes priority over a pending `idx` = 51 decision; no `data_valid` is produced.
  - Outputs from the previous decision are not altered.
- **Symbol alignment.** The first accepted sample after reset release or after `resync` is `idx` 0. Upstream guarantees that the modulator's data input changes only on 52-sample boundaries.

## Timing
- Decision latency: `data_valid` rises 1 cycle after the 52nd accepted sample of a symbol.
- With continuous valid samples starting at cycle 0, pulses occur at cycles 52, 104, 156, …
- Throughput: 1 sample per clock, no back-pressure, no stall output.
- Reset assertion mid-symbol clears everything immediately, without waiting for a clock edge. After release, the first accepted sample is `idx` 0.
- The multiply-accumulate is single-cycle. The path is LUT → 8×8 mult → 20-bit add.

## Structure
- **Package `bpsk_pkg`:**
  - `SYMBOL_LEN` = 52.
  - `SAMPLE_W` = 8.
  - `CORR_W` = 20.
  - The 52-entry signed sine table: 0, 9, 18, 27, 36, 44, 51, 58, 64, 69, 73, 75, 77, 78, 77, …, followed by the negated second half.
  - This package is shared with the modulator.
- **Sub-module `sine_lut`:** combinational, 6-bit index in → signed 8-bit value out. It is instantiated once here and is reusable by the modulator.

## Test plan
- **Ideal bit 1.** Drive 52 continuous valid samples equal to `LUT[0..51]`. Required: `data_valid` at cycle 52, `corr_out` = 156452, `data_out` = 1, `low_conf` = 0.
- **Ideal bit 0.** Drive `LUT[26..51]` followed by `LUT[0..25]`. Required: `corr_out` = −156452, `data_out` = 0, `low_conf` = 0.
- **Zero input.** Drive 52 samples of 0. Required: `corr_out` = 0, `data_out` = 1, `low_conf` = 1.
- **Sequence with gaps.** Send ideal symbols 1, 0, 1 with `sample_valid` deasserted every 3rd cycle. Required:
  - exactly 3 `data_valid` pulses, with bits 1, 0, 1;
  - each pulse 1 cycle after that symbol's 52nd accepted sample;
  - `corr_out` values ±156452.
- **`resync` mid-symbol.** After 20 samples of a 1-symbol, assert `resync` together with `LUT[0]`, then send `LUT[1..51]`. Required: no pulse from the aborted symbol, then one pulse with `corr_out` = 156452.
- **Async reset mid-symbol.** Pull `reset` low at `idx` 30, asynchronous to `clk`. Required: all outputs 0 immediately. After release, a full ideal symbol decodes with `corr_out` = 156452 and the pulse 52 cycles later.
